// File: rtl/mix_columns_engine.sv
// Multi-column AES MixColumns / InvMixColumns engine with valid/ready handshake.
// Transforms COLS_PER_CYCLE columns per clock and holds the result until accepted.
module mix_columns_engine #(
  parameter int NUM_COLS       = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NUM_COLS-1:0] in_state,
  input  logic                  in_encrypt,
  input  logic                  in_bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NUM_COLS-1:0] out_state,
  output logic                  out_encrypt,
  output logic                  busy
);

  localparam int          W   = 32 * NUM_COLS;
  localparam int          GW  = 32 * COLS_PER_CYCLE;
  localparam int          P   = NUM_COLS / COLS_PER_CYCLE;
  localparam int          CW  = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned CPC = COLS_PER_CYCLE;

  if (NUM_COLS < 1 || NUM_COLS > 8 ||
      !(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4 || COLS_PER_CYCLE == 8) ||
      (NUM_COLS % COLS_PER_CYCLE) != 0) begin : g_bad_params
    $error("mix_columns_engine: illegal NUM_COLS/COLS_PER_CYCLE combination");
  end

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic enc);
    logic [7:0] a  [4];
    logic [7:0] m1 [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] m11[4];
    logic [7:0] m13[4];
    logic [7:0] m14[4];
    logic [7:0] m4, m8;
    for (int unsigned r = 0; r < 4; r++) begin
      a[r]   = c[8*r +: 8];
      m1[r]  = a[r];
      m2[r]  = xtime(a[r]);
      m4     = xtime(m2[r]);
      m8     = xtime(m4);
      m3[r]  = m2[r] ^ a[r];
      m9[r]  = m8 ^ a[r];
      m11[r] = m8 ^ m2[r] ^ a[r];
      m13[r] = m8 ^ m4 ^ a[r];
      m14[r] = m8 ^ m4 ^ m2[r];
    end
    if (enc)
      return {m3[0]  ^ m1[1]  ^ m1[2]  ^ m2[3],
              m1[0]  ^ m1[1]  ^ m2[2]  ^ m3[3],
              m1[0]  ^ m2[1]  ^ m3[2]  ^ m1[3],
              m2[0]  ^ m3[1]  ^ m1[2]  ^ m1[3]};
    else
      return {m11[0] ^ m13[1] ^ m9[2]  ^ m14[3],
              m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
              m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
              m14[0] ^ m11[1] ^ m13[2] ^ m9[3]};
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, nxt;
  logic [W-1:0]    work, work_nxt, out_q;
  logic [GW-1:0]   grp_in, grp_out;
  logic [CW-1:0]   cnt;
  logic            enc_q, byp_q, last;

  // Only the column group selected by cnt passes through the transform units.
  always_comb begin
    grp_in   = work[int'(cnt)*GW +: GW];
    grp_out  = '0;
    for (int unsigned i = 0; i < CPC; i++)
      grp_out[32*i +: 32] = mix_col(grp_in[32*i +: 32], enc_q);
    work_nxt = work;
    work_nxt[int'(cnt)*GW +: GW] = grp_out;
    last     = byp_q || (cnt == CW'(P - 1));
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid)  nxt = BUSY;
      BUSY:    if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Bypass spends its one BUSY cycle copying the working state untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      work  <= '0;
      out_q <= '0;
      cnt   <= '0;
      enc_q <= 1'b0;
      byp_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= in_state;
          enc_q <= in_encrypt;
          byp_q <= in_bypass;
          cnt   <= '0;
        end
        BUSY: begin
          if (!byp_q) work <= work_nxt;
          if (last) out_q <= byp_q ? work : work_nxt;
          else      cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign out_state   = out_q;
  assign out_encrypt = enc_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: a 1-column/cycle and a 4-column/cycle instance
// share stimulus; expected states are FIPS-197 / known MixColumns vectors.
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_encrypt, in_bypass, out_ready;
  logic [127:0] in_state;
  logic         in_ready_a, out_valid_a, out_encrypt_a, busy_a;
  logic         in_ready_b, out_valid_b, out_encrypt_b, busy_b;
  logic [127:0] out_state_a, out_state_b;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  mix_columns_engine #(.NUM_COLS(4), .COLS_PER_CYCLE(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_state(in_state), .in_encrypt(in_encrypt), .in_bypass(in_bypass),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_state(out_state_a),
    .out_encrypt(out_encrypt_a), .busy(busy_a)
  );

  mix_columns_engine #(.NUM_COLS(4), .COLS_PER_CYCLE(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_state(in_state), .in_encrypt(in_encrypt), .in_bypass(in_bypass),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_state(out_state_b),
    .out_encrypt(out_encrypt_b), .busy(busy_b)
  );

  typedef struct {
    logic [127:0] st;
    logic         enc;
    logic         byp;
    logic [127:0] exp;
    int           hold;
    bit           poke;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // One transaction on both instances; DONE is held for 'hold' cycles before release.
  task automatic xact(input vec_t v, input string tag);
    int la, lb;
    logic [127:0] held_a, held_b;
    la = 0;
    lb = 0;
    @(negedge clk);
    chk({tag, " in_ready"}, {126'd0, in_ready_a, in_ready_b}, 128'd3);
    in_state   = v.st;
    in_encrypt = v.enc;
    in_bypass  = v.byp;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_state   = ~v.st;
    in_encrypt = ~v.enc;
    in_bypass  = ~v.byp;
    chk({tag, " busy"}, {126'd0, busy_a, busy_b}, 128'd3);
    for (int k = 1; k <= 20 && (la == 0 || lb == 0); k++) begin
      @(posedge clk); #1;
      if (out_valid_a && la == 0) la = k;
      if (out_valid_b && lb == 0) lb = k;
    end
    chk({tag, " latency_a"}, 128'(la), v.byp ? 128'd1 : 128'd4);
    chk({tag, " latency_b"}, 128'(lb), 128'd1);
    chk({tag, " out_state_a"}, out_state_a, v.exp);
    chk({tag, " out_state_b"}, out_state_b, v.exp);
    chk({tag, " out_encrypt"}, {126'd0, out_encrypt_a, out_encrypt_b}, v.enc ? 128'd3 : 128'd0);
    held_a = out_state_a;
    held_b = out_state_b;
    for (int h = 0; h < v.hold; h++) begin
      if (v.poke) begin
        in_valid = 1'b1;
        in_state = 128'hdeadbeef_00000000_12345678_ffffffff;
      end
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, {126'd0, out_valid_a, out_valid_b}, 128'd3);
      chk({tag, " hold_state_a"}, out_state_a, held_a);
      chk({tag, " hold_state_b"}, out_state_b, held_b);
      if (v.poke) chk({tag, " poke_in_ready"}, {126'd0, in_ready_a, in_ready_b}, 128'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " released"}, {124'd0, out_valid_a, out_valid_b, in_ready_a, in_ready_b}, 128'b0011);
  endtask

  initial begin
    tbl[0] = '{st:   {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db}, enc: 1'b1, byp: 1'b0,
               exp:  {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e}, hold: 1, poke: 1'b0};
    tbl[1] = '{st:   {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e}, enc: 1'b0, byp: 1'b0,
               exp:  {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db}, hold: 1, poke: 1'b0};
    tbl[2] = '{st:   {32'he598271e, 32'hf11141b8, 32'hae52b4e0, 32'h305dbfd4}, enc: 1'b1, byp: 1'b0,
               exp:  {32'h4c260628, 32'h7ad3f848, 32'h9a19cbe0, 32'he5816604}, hold: 10, poke: 1'b0};
    tbl[3] = '{st:   {32'h4c260628, 32'h7ad3f848, 32'h9a19cbe0, 32'he5816604}, enc: 1'b0, byp: 1'b0,
               exp:  {32'he598271e, 32'hf11141b8, 32'hae52b4e0, 32'h305dbfd4}, hold: 0, poke: 1'b0};
    tbl[4] = '{st:   128'h0123456789abcdef_fedcba9876543210, enc: 1'b1, byp: 1'b1,
               exp:  128'h0123456789abcdef_fedcba9876543210, hold: 3, poke: 1'b1};
    tbl[5] = '{st:   {32'h4c31262d, 32'hd5d4d4d4, 32'h01010101, 32'hc6c6c6c6}, enc: 1'b1, byp: 1'b0,
               exp:  {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h01010101, 32'hc6c6c6c6}, hold: 0, poke: 1'b0};

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_encrypt = 1'b0;
    in_bypass  = 1'b0;
    in_state   = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags_a", {124'd0, in_ready_a, out_valid_a, out_encrypt_a, busy_a}, 128'b1000);
    chk("reset_flags_b", {124'd0, in_ready_b, out_valid_b, out_encrypt_b, busy_b}, 128'b1000);
    chk("reset_state_a", out_state_a, 128'd0);
    chk("reset_state_b", out_state_b, 128'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) xact(tbl[i], $sformatf("vec%0d", i));

    // Reset while instance a is mid-transform (cnt == 2).
    @(negedge clk);
    in_state   = tbl[0].st;
    in_encrypt = 1'b1;
    in_bypass  = 1'b0;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_busy_a", {126'd0, busy_a, out_valid_a}, 128'b10);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_flags_a", {124'd0, in_ready_a, out_valid_a, out_encrypt_a, busy_a}, 128'b1000);
    chk("midreset_state_a", out_state_a, 128'd0);
    chk("midreset_state_b", out_state_b, 128'd0);
    xact(tbl[0], "post_reset");
    xact(tbl[5], "post_reset2");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
